// File: rtl/reg_write_scheduler_pkg.sv
// Package for the register write scheduler: register-file widths (taken from
// the shared header) and the write-port source selection type.
package reg_write_scheduler_pkg;
    `include "reg_write_scheduler_defs.sv"

    localparam int unsigned REG_ID_W   = `REG_ID_W;
    localparam int unsigned REG_DATA_W = `REG_DATA_W;
    localparam logic [REG_ID_W-1:0] REG_ZERO = `REG_ZERO;

    // Source driving the register-file write port in the current cycle.
    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_PRIMARY,
        SEL_HEAD,
        SEL_DEAD,
        SEL_BYPASS
    } port_sel_e;
endpackage

// File: rtl/reg_write_queue.sv
// Secondary write queue. DEPTH entries, FIFO order, with a live bit per entry.
// Ports:
//   clock, reset_n          clock, synchronous active-low reset
//   push/push_id/push_value enqueue at tail (ignored when full)
//   pop                     drop head (ignored when empty)
//   kill/kill_id            clear live bit of every entry with id kill_id
//   query_rs_id/query_rt_id pending lookups against live entries
//   head_live/id/value      head entry view (head_live=0 when empty)
//   count                   occupied entries, dead ones included
//   rs_pending/rt_pending   some live entry matches the query id (0 for $0)
import reg_write_scheduler_pkg::*;

module reg_write_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ID_W   = REG_ID_W,
    parameter int unsigned DATA_W = REG_DATA_W,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic [ID_W-1:0]   push_id,
    input  logic [DATA_W-1:0] push_value,
    input  logic              pop,
    input  logic              kill,
    input  logic [ID_W-1:0]   kill_id,
    input  logic [ID_W-1:0]   query_rs_id,
    input  logic [ID_W-1:0]   query_rt_id,
    output logic              head_live,
    output logic [ID_W-1:0]   head_id,
    output logic [DATA_W-1:0] head_value,
    output logic [CNT_W-1:0]  count,
    output logic              rs_pending,
    output logic              rt_pending
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [ID_W-1:0]   ids  [DEPTH];
    logic [DATA_W-1:0] vals [DEPTH];
    logic [DEPTH-1:0]  live, live_next;
    logic [IDX_W-1:0]  head_ptr, tail_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              do_push, do_pop;

    // Explicit wrap so non-power-of-two depths stay modulo DEPTH.
    function automatic logic [IDX_W-1:0] bump(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push && (count_q < CNT_W'(DEPTH));
    assign do_pop  = pop && (count_q != '0);

    always_comb begin
        live_next = live;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (kill && ids[i] == kill_id) live_next[i] = 1'b0;
        end
        if (do_pop)  live_next[head_ptr] = 1'b0;
        if (do_push) live_next[tail_ptr] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count_q  <= '0;
            live     <= '0;
        end else begin
            live <= live_next;
            if (do_push) tail_ptr <= bump(tail_ptr);
            if (do_pop)  head_ptr <= bump(head_ptr);
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            ids[tail_ptr]  <= push_id;
            vals[tail_ptr] <= push_value;
        end
    end

    // Unoccupied slots are never live, so scanning every slot is exact.
    always_comb begin
        rs_pending = 1'b0;
        rt_pending = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (live[i] && ids[i] == query_rs_id) rs_pending = 1'b1;
            if (live[i] && ids[i] == query_rt_id) rt_pending = 1'b1;
        end
        if (query_rs_id == '0) rs_pending = 1'b0;
        if (query_rt_id == '0) rt_pending = 1'b0;
    end

    assign head_live  = (count_q != '0) && live[head_ptr];
    assign head_id    = ids[head_ptr];
    assign head_value = vals[head_ptr];
    assign count      = count_q;
endmodule

// File: rtl/reg_write_scheduler_defs.sv
// Shared register-file constants, included by decode, writeback and the
// write scheduler. Holds no logic: only the register id/data widths and the
// id of the hard-wired zero register.
`ifndef REG_WRITE_SCHEDULER_DEFS_SV
`define REG_WRITE_SCHEDULER_DEFS_SV
`define REG_ID_W   5
`define REG_DATA_W 32
`define REG_ZERO   5'd0
`endif

// File: rtl/reg_write_scheduler.sv
// Register-file write port arbiter. The writeback stage (primary) always wins;
// long-latency results (secondary) wait in a reg_write_queue and drain on
// cycles where the primary is idle or writes $0. A primary write kills stale
// queued writes to the same register. All port outputs are combinational.
// Optional build macro: REG_WRITE_SCHED_BYPASS_EN -- when defined, a secondary
// write arriving to an empty queue on an idle port is written the same cycle.
// Ports:
//   clock, reset_n                          clock, synchronous active-low reset
//   wb_write/wb_write_id/wb_write_value     primary write request
//   sec_valid/sec_ready/sec_write_id/value  secondary write handshake
//   query_rs_id/query_rt_id, rs/rt_pending  RAW lookup against queued writes
//   control_reg_write/control_write_id/reg_write_value  write port
//   queue_count                             occupied queue entries
import reg_write_scheduler_pkg::*;

module reg_write_scheduler #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ID_W   = REG_ID_W,
    parameter int unsigned DATA_W = REG_DATA_W
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       wb_write,
    input  logic [ID_W-1:0]            wb_write_id,
    input  logic [DATA_W-1:0]          wb_write_value,
    input  logic                       sec_valid,
    output logic                       sec_ready,
    input  logic [ID_W-1:0]            sec_write_id,
    input  logic [DATA_W-1:0]          sec_write_value,
    input  logic [ID_W-1:0]            query_rs_id,
    input  logic [ID_W-1:0]            query_rt_id,
    output logic                       rs_pending,
    output logic                       rt_pending,
    output logic                       control_reg_write,
    output logic [ID_W-1:0]            control_write_id,
    output logic [DATA_W-1:0]          reg_write_value,
    output logic [$clog2(DEPTH):0]     queue_count
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              wb_active, q_empty, accept, bypass_take;
    logic              push, pop, head_live, q_rs, q_rt;
    logic [ID_W-1:0]   head_id;
    logic [DATA_W-1:0] head_value;
    logic [CNT_W-1:0]  count;
    port_sel_e         sel;

    assign wb_active = wb_write && (wb_write_id != '0);
    assign q_empty   = (count == '0);
    // Readiness uses pre-pop occupancy: a full queue refuses even while popping.
    assign sec_ready = reset_n && (count < CNT_W'(DEPTH));
    assign accept    = sec_valid && sec_ready;

`ifdef REG_WRITE_SCHED_BYPASS_EN
    assign bypass_take = reset_n && q_empty && !wb_active && sec_valid && (sec_write_id != '0);
`else
    assign bypass_take = 1'b0;
`endif

    // $0 writes and writes overtaken by a same-id primary are acked and dropped.
    assign push = accept && (sec_write_id != '0) && !bypass_take
               && !(wb_active && sec_write_id == wb_write_id);
    assign pop  = reset_n && !q_empty && !wb_active;

    always_comb begin
        sel = SEL_NONE;
        if (!reset_n)          sel = SEL_NONE;
        else if (wb_active)    sel = SEL_PRIMARY;
        else if (bypass_take)  sel = SEL_BYPASS;
        else if (!q_empty)     sel = head_live ? SEL_HEAD : SEL_DEAD;
    end

    always_comb begin
        control_reg_write = 1'b0;
        control_write_id  = head_id;
        reg_write_value   = head_value;
        case (sel)
            SEL_PRIMARY: begin
                control_reg_write = 1'b1;
                control_write_id  = wb_write_id;
                reg_write_value   = wb_write_value;
            end
            SEL_BYPASS: begin
                control_reg_write = 1'b1;
                control_write_id  = sec_write_id;
                reg_write_value   = sec_write_value;
            end
            SEL_HEAD: control_reg_write = 1'b1;
            default:  control_reg_write = 1'b0;
        endcase
    end

    reg_write_queue #(
        .DEPTH  (DEPTH),
        .ID_W   (ID_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_queue (
        .clock       (clock),
        .reset_n     (reset_n),
        .push        (push),
        .push_id     (sec_write_id),
        .push_value  (sec_write_value),
        .pop         (pop),
        .kill        (wb_active),
        .kill_id     (wb_write_id),
        .query_rs_id (query_rs_id),
        .query_rt_id (query_rt_id),
        .head_live   (head_live),
        .head_id     (head_id),
        .head_value  (head_value),
        .count       (count),
        .rs_pending  (q_rs),
        .rt_pending  (q_rt)
    );

    // Live bits may be stale until the first reset edge, so gate lookups too.
    assign rs_pending  = reset_n && q_rs;
    assign rt_pending  = reset_n && q_rt;
    assign queue_count = count;
endmodule

// File: tb/tb_reg_write_scheduler.sv
// Randomised bench for reg_write_scheduler with a queue-level reference model
// plus directed scenarios for reset, fill/drain, WAW kill, $0 and bypass.
module tb_reg_write_scheduler;
    localparam int unsigned DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset_n, wb_write, sec_valid, sec_ready;
    logic [4:0]  wb_write_id, sec_write_id, query_rs_id, query_rt_id, control_write_id;
    logic [31:0] wb_write_value, sec_write_value, reg_write_value;
    logic        rs_pending, rt_pending, control_reg_write;
    logic [2:0]  queue_count;

    always #5 clock = ~clock;

    reg_write_scheduler #(.DEPTH(DEPTH), .ID_W(5), .DATA_W(32)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .wb_write          (wb_write),
        .wb_write_id       (wb_write_id),
        .wb_write_value    (wb_write_value),
        .sec_valid         (sec_valid),
        .sec_ready         (sec_ready),
        .sec_write_id      (sec_write_id),
        .sec_write_value   (sec_write_value),
        .query_rs_id       (query_rs_id),
        .query_rt_id       (query_rt_id),
        .rs_pending        (rs_pending),
        .rt_pending        (rt_pending),
        .control_reg_write (control_reg_write),
        .control_write_id  (control_write_id),
        .reg_write_value   (reg_write_value),
        .queue_count       (queue_count)
    );

    typedef struct {
        logic [4:0]  id;
        logic [31:0] value;
        bit          live;
    } entry_t;

    entry_t mq[$];
    bit     count_known = 0;
    int     checks = 0;
    int     errors = 0;
    bit     m_wb_act, m_bypass, m_ready;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit model_pending(input logic [4:0] q);
        if (q == 5'd0) return 0;
        foreach (mq[i]) if (mq[i].live && mq[i].id == q) return 1;
        return 0;
    endfunction

    // Drive inputs mid-cycle and compare every output against the model.
    task automatic apply(input logic rn, input logic wb, input logic [4:0] wid,
                         input logic [31:0] wval, input logic sv, input logic [4:0] sid,
                         input logic [31:0] sval, input logic [4:0] qrs, input logic [4:0] qrt);
        bit          exp_wr;
        logic [4:0]  exp_id;
        logic [31:0] exp_val;
        @(negedge clock);
        reset_n = rn; wb_write = wb; wb_write_id = wid; wb_write_value = wval;
        sec_valid = sv; sec_write_id = sid; sec_write_value = sval;
        query_rs_id = qrs; query_rt_id = qrt;
        #1;
        m_wb_act = wb && wid != 5'd0;
        m_ready  = rn && (mq.size() < DEPTH);
`ifdef REG_WRITE_SCHED_BYPASS_EN
        m_bypass = rn && mq.size() == 0 && !m_wb_act && sv && sid != 5'd0;
`else
        m_bypass = 0;
`endif
        exp_wr = 0; exp_id = '0; exp_val = '0;
        if (!rn) exp_wr = 0;
        else if (m_wb_act) begin exp_wr = 1; exp_id = wid; exp_val = wval; end
        else if (m_bypass) begin exp_wr = 1; exp_id = sid; exp_val = sval; end
        else if (mq.size() > 0 && mq[0].live) begin
            exp_wr = 1; exp_id = mq[0].id; exp_val = mq[0].value;
        end
        check_eq("wr_en", control_reg_write, exp_wr);
        if (exp_wr) begin
            check_eq("wr_id", control_write_id, exp_id);
            check_eq("wr_val", reg_write_value, exp_val);
        end
        check_eq("sec_ready", sec_ready, m_ready);
        check_eq("rs_pend", rs_pending, rn && model_pending(qrs));
        check_eq("rt_pend", rt_pending, rn && model_pending(qrt));
        if (count_known) check_eq("count", queue_count, mq.size());
    endtask

    // Advance through the posedge and update the model with the cycle's rules.
    task automatic tick();
        @(posedge clock);
        if (!reset_n) begin
            mq.delete();
            count_known = 1;
        end else begin
            if (m_wb_act) foreach (mq[i]) if (mq[i].id == wb_write_id) mq[i].live = 0;
            if (mq.size() > 0 && !m_wb_act) void'(mq.pop_front());
            if (sec_valid && m_ready && sec_write_id != 5'd0 && !m_bypass
                && !(m_wb_act && sec_write_id == wb_write_id))
                mq.push_back('{sec_write_id, sec_write_value, 1'b1});
        end
    endtask

    task automatic idle_cycle(input logic [4:0] qrs);
        apply(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, qrs, 5'd0);
    endtask

    initial begin
        // Reset with a secondary offer present.
        apply(0, 0, 5'd0, 32'd0, 1, 5'd7, 32'h77, 5'd7, 5'd0);
        check_eq("rst_ready", sec_ready, 0);
        check_eq("rst_wr", control_reg_write, 0);
        tick();
        apply(0, 0, 5'd0, 32'd0, 1, 5'd7, 32'h77, 5'd0, 5'd0);
        check_eq("rst_count", queue_count, 0);
        tick();

        // Fill with 5,6,7,8 behind a busy primary, then drain in order.
        for (int i = 0; i < 4; i++) begin
            apply(1, 1, 5'd1, 32'h100 + i, 1, 5'(5 + i), 32'h500 + i, 5'd0, 5'd0);
            tick();
        end
        apply(1, 1, 5'd1, 32'h1, 1, 5'd9, 32'h9, 5'd8, 5'd5);
        check_eq("full_ready", sec_ready, 0);
        check_eq("full_count", queue_count, 4);
        tick();
        for (int i = 0; i < 4; i++) begin
            idle_cycle(5'd0);
            check_eq("drain_id", control_write_id, 5 + i);
            tick();
        end
        idle_cycle(5'd0);
        check_eq("drain_idle", control_reg_write, 0);
        tick();

        // WAW kill: queued id 9 overtaken by primary id 9.
        apply(1, 1, 5'd1, 32'h1, 1, 5'd9, 32'hAAAA_AAAA, 5'd0, 5'd0);
        tick();
        apply(1, 1, 5'd9, 32'h1234_5678, 0, 5'd0, 32'd0, 5'd9, 5'd0);
        check_eq("waw_val", reg_write_value, 32'h1234_5678);
        tick();
        idle_cycle(5'd9);
        check_eq("waw_pend", rs_pending, 0);
        check_eq("dead_pop", control_reg_write, 0);
        tick();

        // Primary busy on id 3 while id 4 waits.
        apply(1, 1, 5'd3, 32'h3, 1, 5'd4, 32'h44, 5'd4, 5'd0);
        tick();
        for (int i = 0; i < 2; i++) begin
            apply(1, 1, 5'd3, 32'h3, 0, 5'd0, 32'd0, 5'd4, 5'd0);
            check_eq("busy_pend", rs_pending, 1);
            tick();
        end
        idle_cycle(5'd4);
        check_eq("late_id", control_write_id, 4);
        check_eq("late_pend", rs_pending, 1);
        tick();
        idle_cycle(5'd4);
        check_eq("after_pend", rs_pending, 0);
        tick();

        // $0 writes from both sides.
        apply(1, 1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF, 5'd0, 5'd0);
        check_eq("zero_wr", control_reg_write, 0);
        check_eq("zero_ack", sec_ready, 1);
        tick();
        idle_cycle(5'd0);
        check_eq("zero_count", queue_count, 0);
        tick();

        // Secondary to an empty queue on an idle port.
        apply(1, 0, 5'd0, 32'd0, 1, 5'd12, 32'h0000_00FF, 5'd0, 5'd0);
`ifdef REG_WRITE_SCHED_BYPASS_EN
        check_eq("byp_wr", control_reg_write, 1);
        check_eq("byp_id", control_write_id, 12);
`else
        check_eq("byp_wr", control_reg_write, 0);
`endif
        tick();
        idle_cycle(5'd0);
`ifdef REG_WRITE_SCHED_BYPASS_EN
        check_eq("byp_count", queue_count, 0);
        check_eq("byp_next", control_reg_write, 0);
`else
        check_eq("q_next", control_reg_write, 1);
        check_eq("q_next_id", control_write_id, 12);
`endif
        tick();

        // Randomised traffic with a small id space to force collisions.
        for (int n = 0; n < 3000; n++) begin
            logic       rn, wb, sv;
            logic [4:0] wid, sid, qrs, qrt;
            rn  = ($urandom_range(0, 99) >= 2);
            wb  = ($urandom_range(0, 99) < 45);
            sv  = ($urandom_range(0, 99) < 60);
            wid = 5'($urandom_range(0, 7));
            sid = 5'($urandom_range(0, 7));
            qrs = 5'($urandom_range(0, 7));
            qrt = 5'($urandom_range(0, 31));
            apply(rn, wb, wid, $urandom, sv, sid, $urandom, qrs, qrt);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
